// File: rtl/pcileech_sysctl_seq_if.sv
// pcileech_sysctl_seq_if
// Board-side signal bundle of the system-control sequencer: button pads,
// the fifo-core reload handshake and the sequencer outputs.
// The board/testbench side uses the master modport and the sequencer uses
// the slave modport.
// Optional macro PCILEECH_SYSCTL_WDOG_EN adds the watchdog kick/fired pair.
interface pcileech_sysctl_seq_if;
    logic        btn_rst_n;
    logic        btn_inv_n;
    logic        reload_ack;
    logic        rst_core;
    logic        cfg_reload_req;
    logic        led_pwronblink;
    logic [63:0] uptime;
    logic [2:0]  seq_state;
`ifdef PCILEECH_SYSCTL_WDOG_EN
    logic        wdog_kick;
    logic        wdog_fired;
`endif

    modport master (
        output btn_rst_n,
        output btn_inv_n,
        output reload_ack,
`ifdef PCILEECH_SYSCTL_WDOG_EN
        output wdog_kick,
        input  wdog_fired,
`endif
        input  rst_core,
        input  cfg_reload_req,
        input  led_pwronblink,
        input  uptime,
        input  seq_state
    );

    modport slave (
        input  btn_rst_n,
        input  btn_inv_n,
        input  reload_ack,
`ifdef PCILEECH_SYSCTL_WDOG_EN
        input  wdog_kick,
        output wdog_fired,
`endif
        output rst_core,
        output cfg_reload_req,
        output led_pwronblink,
        output uptime,
        output seq_state
    );
endinterface

// File: rtl/pcileech_sysctl_seq.sv
// pcileech_sysctl_seq
// System-control sequencer: synchronizes and debounces the reset button,
// sequences core reset / config reload, and drives the power-on blink LED.
// Optional macro PCILEECH_SYSCTL_WDOG_EN adds a run-time watchdog that
// forces a normal core reset when it is not kicked in time.
module pcileech_sysctl_seq #(
    parameter int unsigned DEBOUNCE_CYCLES    = 1000000,
    parameter int unsigned RST_HOLD_CYCLES    = 64,
    parameter int unsigned RELOAD_HOLD_CYCLES = 500000000,
    parameter int unsigned BLINK_BIT          = 24,
    parameter int unsigned BLINK_WINDOW_BIT   = 27
`ifdef PCILEECH_SYSCTL_WDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES        = 1000000000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    pcileech_sysctl_seq_if.slave sys
);

    typedef enum logic [2:0] {
        S_RST      = 3'd0,
        S_RUN      = 3'd1,
        S_HELD     = 3'd2,
        S_RELOAD   = 3'd3,
        S_WAIT_REL = 3'd4
    } state_e;

    localparam logic [31:0] DEB_LAST    = 32'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [31:0] RST_LAST    = 32'(RST_HOLD_CYCLES - 32'd1);
    localparam logic [31:0] RELOAD_LAST = 32'(RELOAD_HOLD_CYCLES - 32'd1);

    // synchronizer flops
    logic        btn_rst_meta_q, btn_rst_sync_q;
    logic        btn_inv_meta_q, btn_inv_sync_q;

    // debounce: deb_q is the debounced active-low button level (1 = released)
    logic        deb_q, deb_d;
    logic [31:0] deb_cnt_q, deb_cnt_d;
    logic        pressed_s;

    // sequencer state and counters
    state_e      state_q, state_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic        ack_arm_q;
    logic [63:0] uptime_q, uptime_d;

    // registered outputs
    logic        rst_core_q;
    logic        cfg_reload_req_q;
    logic        led_q, led_d;

`ifdef PCILEECH_SYSCTL_WDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 32'd1);
    logic [31:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_expire_s;
    logic        wdog_fired_q;
`endif

    // Reset-button synchronizer; forced to "released" during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_rst_meta_q <= 1'b1;
            btn_rst_sync_q <= 1'b1;
        end else begin
            btn_rst_meta_q <= sys.btn_rst_n;
            btn_rst_sync_q <= btn_rst_meta_q;
        end
    end

    // Invert-switch synchronizer; free-running so the LED follows it in reset.
    always_ff @(posedge clk) begin
        btn_inv_meta_q <= sys.btn_inv_n;
        btn_inv_sync_q <= btn_inv_meta_q;
    end

    // Debounce: flip the level only after DEBOUNCE_CYCLES of disagreement.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = 32'd0;
        if (btn_rst_sync_q == deb_q) begin
            deb_cnt_d = 32'd0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_d     = btn_rst_sync_q;
            deb_cnt_d = 32'd0;
        end else begin
            deb_cnt_d = deb_cnt_q + 32'd1;
        end
    end

    // The FSM reacts to the debounced edge in the cycle it is registered.
    assign pressed_s = ~deb_d;

`ifdef PCILEECH_SYSCTL_WDOG_EN
    // Watchdog counter: runs only in S_RUN, a kick always wins over expiry.
    always_comb begin
        wdog_cnt_d    = 32'd0;
        wdog_expire_s = 1'b0;
        if (state_q != S_RUN) begin
            wdog_cnt_d = 32'd0;
        end else if (sys.wdog_kick) begin
            wdog_cnt_d = 32'd0;
        end else if (wdog_cnt_q == WDOG_LAST) begin
            wdog_cnt_d    = 32'd0;
            wdog_expire_s = 1'b1;
        end else begin
            wdog_cnt_d = wdog_cnt_q + 32'd1;
        end
    end
`endif

    // Next-state logic for the reset / reload sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: begin
                if (hold_cnt_q == RST_LAST) begin
                    state_d = pressed_s ? S_HELD : S_RUN;
                end else begin
                    state_d = S_RST;
                end
            end
            S_RUN: begin
                if (pressed_s) begin
                    state_d = S_HELD;
`ifdef PCILEECH_SYSCTL_WDOG_EN
                end else if (wdog_expire_s) begin
                    state_d = S_RST;
`endif
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HELD: begin
                if (!pressed_s) begin
                    state_d = S_RST;
                end else if (hold_cnt_q == RELOAD_LAST) begin
                    state_d = S_RELOAD;
                end else begin
                    state_d = S_HELD;
                end
            end
            S_RELOAD: begin
                // the ack only counts once the request has been up a full cycle
                if (sys.reload_ack && ack_arm_q) begin
                    state_d = S_WAIT_REL;
                end else begin
                    state_d = S_RELOAD;
                end
            end
            S_WAIT_REL: begin
                if (!pressed_s) begin
                    state_d = S_RST;
                end else begin
                    state_d = S_WAIT_REL;
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    // Counter and LED next values derived from the state transition.
    always_comb begin
        hold_cnt_d = 32'd0;
        uptime_d   = 64'd0;
        if (state_d != state_q) begin
            hold_cnt_d = 32'd0;
        end else begin
            hold_cnt_d = hold_cnt_q + 32'd1;
        end
        // uptime stays 0 on the first run cycle so it reads "cycles since release"
        if ((state_q == S_RUN) && (state_d == S_RUN)) begin
            uptime_d = (&uptime_q) ? uptime_q : (uptime_q + 64'd1);
        end else begin
            uptime_d = 64'd0;
        end
        led_d = ~btn_inv_sync_q ^
                (uptime_d[BLINK_BIT] & ~(|uptime_d[63:BLINK_WINDOW_BIT]));
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q            <= 1'b1;
            deb_cnt_q        <= 32'd0;
            state_q          <= S_RST;
            hold_cnt_q       <= 32'd0;
            ack_arm_q        <= 1'b0;
            uptime_q         <= 64'd0;
            rst_core_q       <= 1'b1;
            cfg_reload_req_q <= 1'b0;
            led_q            <= ~btn_inv_sync_q;
        end else begin
            deb_q            <= deb_d;
            deb_cnt_q        <= deb_cnt_d;
            state_q          <= state_d;
            hold_cnt_q       <= hold_cnt_d;
            ack_arm_q        <= (state_q == S_RELOAD) && (state_d == S_RELOAD);
            uptime_q         <= uptime_d;
            rst_core_q       <= (state_d != S_RUN);
            cfg_reload_req_q <= (state_d == S_RELOAD);
            led_q            <= led_d;
        end
    end

`ifdef PCILEECH_SYSCTL_WDOG_EN
    // Watchdog counter and sticky fired flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q   <= 32'd0;
            wdog_fired_q <= 1'b0;
        end else begin
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_fired_q <= wdog_fired_q | wdog_expire_s;
        end
    end

    assign sys.wdog_fired = wdog_fired_q;
`endif

    assign sys.rst_core       = rst_core_q;
    assign sys.cfg_reload_req = cfg_reload_req_q;
    assign sys.led_pwronblink = led_q;
    assign sys.uptime         = uptime_q;
    assign sys.seq_state      = state_q;

endmodule

// File: tb/tb_pcileech_sysctl_seq.sv
// tb_pcileech_sysctl_seq
// Directed bench for pcileech_sysctl_seq with small timing parameters
// (DEBOUNCE=4, RST_HOLD=8, RELOAD_HOLD=20, BLINK_BIT=2, BLINK_WINDOW_BIT=4).
// Watchdog checks are built when PCILEECH_SYSCTL_WDOG_EN is defined.
module tb_pcileech_sysctl_seq;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    pcileech_sysctl_seq_if sys_if ();

    pcileech_sysctl_seq #(
        .DEBOUNCE_CYCLES    (4),
        .RST_HOLD_CYCLES    (8),
        .RELOAD_HOLD_CYCLES (20),
        .BLINK_BIT          (2),
        .BLINK_WINDOW_BIT   (4)
`ifdef PCILEECH_SYSCTL_WDOG_EN
        ,
        .WDOG_CYCLES        (10)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .sys (sys_if)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance n clocks; sample/drive 1 ns after the rising edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        sys_if.btn_rst_n  = 1'b1;
        sys_if.btn_inv_n  = 1'b1;
        sys_if.reload_ack = 1'b0;
`ifdef PCILEECH_SYSCTL_WDOG_EN
        sys_if.wdog_kick  = 1'b1;
`endif

        // 1. power-on reset, then exactly 8 cycles of rst_core
        step(3);
        chk("rst_rst_core", {63'd0, sys_if.rst_core}, 64'd1);
        chk("rst_req", {63'd0, sys_if.cfg_reload_req}, 64'd0);
        chk("rst_uptime", sys_if.uptime, 64'd0);
        chk("rst_state", {61'd0, sys_if.seq_state}, 64'd0);
        chk("rst_led", {63'd0, sys_if.led_pwronblink}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("hold_rst_core", {63'd0, sys_if.rst_core}, 64'd1);
            step(1);
        end
        chk("run_rst_core", {63'd0, sys_if.rst_core}, 64'd0);
        chk("run_state", {61'd0, sys_if.seq_state}, 64'd1);
        step(1);
        chk("run_uptime1", sys_if.uptime, 64'd1);

        // reload_ack outside S_RELOAD is ignored
        sys_if.reload_ack = 1'b1;
        step(1);
        sys_if.reload_ack = 1'b0;
        chk("ack_in_run", {61'd0, sys_if.seq_state}, 64'd1);

        // 2. 3-cycle glitch is filtered
        sys_if.btn_rst_n = 1'b0;
        step(3);
        sys_if.btn_rst_n = 1'b1;
        step(8);
        chk("glitch_state", {61'd0, sys_if.seq_state}, 64'd1);
        chk("glitch_rst_core", {63'd0, sys_if.rst_core}, 64'd0);

        // 10-cycle press: S_HELD 6 cycles after the raw edge, then plain reset
        sys_if.btn_rst_n = 1'b0;
        step(5);
        chk("press_early", {61'd0, sys_if.seq_state}, 64'd1);
        step(1);
        chk("press_held", {61'd0, sys_if.seq_state}, 64'd2);
        chk("press_rst_core", {63'd0, sys_if.rst_core}, 64'd1);
        step(4);
        sys_if.btn_rst_n = 1'b1;
        step(5);
        chk("short_still_held", {61'd0, sys_if.seq_state}, 64'd2);
        step(1);
        chk("short_to_rst", {61'd0, sys_if.seq_state}, 64'd0);
        chk("short_no_req", {63'd0, sys_if.cfg_reload_req}, 64'd0);
        step(7);
        chk("short_rst_hold", {63'd0, sys_if.rst_core}, 64'd1);
        step(1);
        chk("short_rst_done", {63'd0, sys_if.rst_core}, 64'd0);
        chk("short_run", {61'd0, sys_if.seq_state}, 64'd1);

        // 3/4. long press: reload request, ack handling
        sys_if.btn_rst_n = 1'b0;
        step(6);
        chk("long_held", {61'd0, sys_if.seq_state}, 64'd2);
        sys_if.reload_ack = 1'b1;
        step(1);
        sys_if.reload_ack = 1'b0;
        chk("ack_in_held", {61'd0, sys_if.seq_state}, 64'd2);
        step(18);
        chk("req_before", {63'd0, sys_if.cfg_reload_req}, 64'd0);
        step(1);
        chk("req_up", {63'd0, sys_if.cfg_reload_req}, 64'd1);
        chk("reload_state", {61'd0, sys_if.seq_state}, 64'd3);
        sys_if.reload_ack = 1'b1;
        step(1);
        sys_if.reload_ack = 1'b0;
        chk("entry_ack_state", {61'd0, sys_if.seq_state}, 64'd3);
        chk("entry_ack_req", {63'd0, sys_if.cfg_reload_req}, 64'd1);
        step(4);
        sys_if.reload_ack = 1'b1;
        step(1);
        sys_if.reload_ack = 1'b0;
        chk("ack_req_low", {63'd0, sys_if.cfg_reload_req}, 64'd0);
        chk("ack_wait_rel", {61'd0, sys_if.seq_state}, 64'd4);
        chk("ack_rst_core", {63'd0, sys_if.rst_core}, 64'd1);
        step(8);
        sys_if.btn_rst_n = 1'b1;
        step(5);
        chk("rel_still_wait", {61'd0, sys_if.seq_state}, 64'd4);
        step(1);
        chk("rel_to_rst", {61'd0, sys_if.seq_state}, 64'd0);
        step(7);
        chk("rel_rst_hold", {63'd0, sys_if.rst_core}, 64'd1);
        step(1);
        chk("rel_run", {61'd0, sys_if.seq_state}, 64'd1);

        // 6. release in S_RELOAD keeps the request; rst drops it
        sys_if.btn_rst_n = 1'b0;
        step(26);
        chk("reload2_state", {61'd0, sys_if.seq_state}, 64'd3);
        sys_if.btn_rst_n = 1'b1;
        step(10);
        chk("reload_kept_state", {61'd0, sys_if.seq_state}, 64'd3);
        chk("reload_kept_req", {63'd0, sys_if.cfg_reload_req}, 64'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_req", {63'd0, sys_if.cfg_reload_req}, 64'd0);
        chk("mid_rst_state", {61'd0, sys_if.seq_state}, 64'd0);
        chk("mid_rst_core", {63'd0, sys_if.rst_core}, 64'd1);

        // 5. blink pattern tied to uptime bits 2 and 4
        step(8);
        chk("blink_run", {61'd0, sys_if.seq_state}, 64'd1);
        for (int i = 0; i < 40; i++) begin
            chk("blink_uptime", sys_if.uptime, 64'(i));
            chk("blink_led", {63'd0, sys_if.led_pwronblink},
                {63'd0, ((i & 4) != 0) && (i < 16)});
            step(1);
        end

        // inverted LED sense
        sys_if.btn_inv_n = 1'b0;
        rst = 1'b1;
        step(3);
        chk("inv_rst_led", {63'd0, sys_if.led_pwronblink}, 64'd1);
        rst = 1'b0;
        step(8);
        for (int i = 0; i < 16; i++) begin
            chk("inv_led", {63'd0, sys_if.led_pwronblink},
                {63'd0, (i & 4) == 0});
            step(1);
        end

`ifdef PCILEECH_SYSCTL_WDOG_EN
        // watchdog: kicks every 5 cycles keep it quiet
        for (int i = 0; i < 8; i++) begin
            sys_if.wdog_kick = 1'b0;
            step(4);
            sys_if.wdog_kick = 1'b1;
            step(1);
        end
        chk("wdog_kicked_fired", {63'd0, sys_if.wdog_fired}, 64'd0);
        chk("wdog_kicked_state", {61'd0, sys_if.seq_state}, 64'd1);
        // no kick: fires after 10 run cycles
        sys_if.wdog_kick = 1'b0;
        step(9);
        chk("wdog_pre_fire", {63'd0, sys_if.wdog_fired}, 64'd0);
        step(1);
        chk("wdog_fired", {63'd0, sys_if.wdog_fired}, 64'd1);
        chk("wdog_rst_core", {63'd0, sys_if.rst_core}, 64'd1);
        chk("wdog_state", {61'd0, sys_if.seq_state}, 64'd0);
        sys_if.wdog_kick = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
